// File: rtl/frogger_game_seq.sv
// Frogger game-level sequencer: run state, lives, level and round timer,
// stepped by video frame ticks.
module frogger_game_seq #(
    parameter int unsigned LIVES_INIT     = 3,
    parameter int unsigned TICKS_PER_SEC  = 60,
    parameter int unsigned ROUND_SECS     = 30,
    parameter int unsigned DEATH_FRAMES   = 90,
    parameter int unsigned LEVELUP_FRAMES = 60,
    parameter int unsigned PADS_PER_LEVEL = 5,
    parameter int unsigned MAX_LEVEL      = 7
) (
    input  logic       i_Clk,
    input  logic       i_Rst_L,
    input  logic       i_Frame_Tick,
    input  logic       i_Start,
    input  logic       i_Collided,
    input  logic [6:0] i_Score,
    output logic [2:0] o_Game_State,
    output logic       o_Move_En,
    output logic       o_Respawn,
    output logic       o_Clear_Score,
    output logic [2:0] o_Lives,
    output logic [2:0] o_Level,
    output logic [5:0] o_Timer
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_PLAY      = 3'd1,
        S_DYING     = 3'd2,
        S_LEVEL_UP  = 3'd3,
        S_GAME_OVER = 3'd4
    } state_t;

    localparam logic [2:0] LIVES_RST  = 3'(LIVES_INIT);
    localparam logic [5:0] ROUND_RST  = 6'(ROUND_SECS);
    localparam logic [6:0] SEC_LAST   = 7'(TICKS_PER_SEC - 1);
    localparam logic [6:0] DEATH_LAST = 7'(DEATH_FRAMES - 1);
    localparam logic [6:0] LVLUP_LAST = 7'(LEVELUP_FRAMES - 1);
    localparam logic [2:0] PADS_LVL   = 3'(PADS_PER_LEVEL);
    localparam logic [2:0] LEVEL_MAX  = 3'(MAX_LEVEL);

    state_t     state_q, state_d;
    logic [2:0] lives_q, lives_d;
    logic [2:0] level_q, level_d;
    logic [5:0] timer_q, timer_d;
    logic [2:0] pads_q, pads_d;
    logic [6:0] sec_cnt_q, sec_cnt_d;
    logic [6:0] frame_cnt_q, frame_cnt_d;
    logic       move_en_q, move_en_d;
    logic       respawn_q, respawn_d;
    logic       clear_q, clear_d;
    logic       start_prev_q;
    logic [6:0] score_prev_q;

    logic       start_edge;
    logic       pad_evt;
    logic       timer_expire;
    logic [2:0] pads_inc;
    logic [2:0] lives_dec;

    assign start_edge = i_Start & ~start_prev_q;
    assign pad_evt    = (i_Score > score_prev_q);
    assign pads_inc   = pads_q + 3'd1;
    assign lives_dec  = (lives_q != 3'd0) ? lives_q - 3'd1 : 3'd0;

    always_ff @(posedge i_Clk or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q      <= S_IDLE;
            lives_q      <= LIVES_RST;
            level_q      <= 3'd1;
            timer_q      <= ROUND_RST;
            pads_q       <= '0;
            sec_cnt_q    <= '0;
            frame_cnt_q  <= '0;
            move_en_q    <= 1'b0;
            respawn_q    <= 1'b0;
            clear_q      <= 1'b0;
            start_prev_q <= 1'b0;
            score_prev_q <= '0;
        end else begin
            state_q      <= state_d;
            lives_q      <= lives_d;
            level_q      <= level_d;
            timer_q      <= timer_d;
            pads_q       <= pads_d;
            sec_cnt_q    <= sec_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            move_en_q    <= move_en_d;
            respawn_q    <= respawn_d;
            clear_q      <= clear_d;
            start_prev_q <= i_Start;
            score_prev_q <= i_Score;
        end
    end

    always_comb begin
        state_d      = state_q;
        lives_d      = lives_q;
        level_d      = level_q;
        timer_d      = timer_q;
        pads_d       = pads_q;
        sec_cnt_d    = sec_cnt_q;
        frame_cnt_d  = frame_cnt_q;
        respawn_d    = 1'b0;
        clear_d      = 1'b0;
        timer_expire = 1'b0;

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (start_edge) begin
                    state_d   = S_PLAY;
                    lives_d   = LIVES_RST;
                    level_d   = 3'd1;
                    timer_d   = ROUND_RST;
                    pads_d    = '0;
                    sec_cnt_d = '0;
                    respawn_d = 1'b1;
                    clear_d   = 1'b1;
                end
            end
            S_PLAY: begin
                if (i_Frame_Tick) begin
                    if (sec_cnt_q == SEC_LAST) begin
                        sec_cnt_d = '0;
                        if (timer_q != 6'd0) begin
                            timer_d      = timer_q - 6'd1;
                            timer_expire = (timer_q == 6'd1);
                        end
                    end else begin
                        sec_cnt_d = sec_cnt_q + 7'd1;
                    end
                end
                // Collision outranks a pad landing in the same cycle.
                if (i_Collided) begin
                    state_d     = S_DYING;
                    lives_d     = lives_dec;
                    frame_cnt_d = '0;
                end else if (pad_evt) begin
                    pads_d = pads_inc;
                    if (pads_inc == PADS_LVL) begin
                        state_d     = S_LEVEL_UP;
                        frame_cnt_d = '0;
                    end
                end else if (timer_expire) begin
                    state_d     = S_DYING;
                    lives_d     = lives_dec;
                    frame_cnt_d = '0;
                end
            end
            S_DYING: begin
                if (i_Frame_Tick) begin
                    if (frame_cnt_q == DEATH_LAST) begin
                        if (lives_q == 3'd0) begin
                            state_d = S_GAME_OVER;
                        end else begin
                            state_d   = S_PLAY;
                            timer_d   = ROUND_RST;
                            sec_cnt_d = '0;
                            respawn_d = 1'b1;
                        end
                    end else begin
                        frame_cnt_d = frame_cnt_q + 7'd1;
                    end
                end
            end
            S_LEVEL_UP: begin
                if (i_Frame_Tick) begin
                    if (frame_cnt_q == LVLUP_LAST) begin
                        level_d   = (level_q >= LEVEL_MAX) ? LEVEL_MAX : level_q + 3'd1;
                        pads_d    = '0;
                        timer_d   = ROUND_RST;
                        state_d   = S_PLAY;
                        respawn_d = 1'b1;
                    end else begin
                        frame_cnt_d = frame_cnt_q + 7'd1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        move_en_d = (state_d == S_PLAY);
    end

    assign o_Game_State  = state_q;
    assign o_Move_En     = move_en_q;
    assign o_Respawn     = respawn_q;
    assign o_Clear_Score = clear_q;
    assign o_Lives       = lives_q;
    assign o_Level       = level_q;
    assign o_Timer       = timer_q;

endmodule

// File: tb/tb_frogger_game_seq.sv
// Directed bench for frogger_game_seq: stimulus queues hand-computed expected
// outputs, a negedge monitor pops and compares them.
module tb_frogger_game_seq;

    typedef struct packed {
        logic [2:0] st;
        logic       me;
        logic       rs;
        logic       cl;
        logic [2:0] lv;
        logic [2:0] lev;
        logic [5:0] tm;
    } exp_t;

    localparam logic [2:0] ID = 3'd0, PL = 3'd1, DY = 3'd2, LU = 3'd3, GO = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic       coll = 1'b0;
    logic [6:0] score = '0;
    logic [2:0] game_state;
    logic       move_en, respawn, clear_score;
    logic [2:0] lives, level;
    logic [5:0] timer;

    exp_t exp_q[$];
    int   id_q[$];
    int   next_id = 0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    frogger_game_seq #(
        .LIVES_INIT    (2),
        .TICKS_PER_SEC (2),
        .ROUND_SECS    (3),
        .DEATH_FRAMES  (4),
        .LEVELUP_FRAMES(3),
        .PADS_PER_LEVEL(2),
        .MAX_LEVEL     (7)
    ) dut (
        .i_Clk        (clk),
        .i_Rst_L      (rst_n),
        .i_Frame_Tick (tick),
        .i_Start      (start),
        .i_Collided   (coll),
        .i_Score      (score),
        .o_Game_State (game_state),
        .o_Move_En    (move_en),
        .o_Respawn    (respawn),
        .o_Clear_Score(clear_score),
        .o_Lives      (lives),
        .o_Level      (level),
        .o_Timer      (timer)
    );

    task automatic push(input logic [2:0] st, input logic me, input logic rs, input logic cl,
                        input logic [2:0] lv, input logic [2:0] lev, input logic [5:0] tm);
        exp_t e;
        e.st = st; e.me = me; e.rs = rs; e.cl = cl; e.lv = lv; e.lev = lev; e.tm = tm;
        exp_q.push_back(e);
        id_q.push_back(next_id);
        next_id++;
    endtask

    task automatic cyc(input logic s, input logic t, input logic c, input logic [6:0] sc,
                       input logic [2:0] st, input logic me, input logic rs, input logic cl,
                       input logic [2:0] lv, input logic [2:0] lev, input logic [5:0] tm);
        @(negedge clk);
        start = s; tick = t; coll = c; score = sc;
        @(posedge clk);
        #1;
        push(st, me, rs, cl, lv, lev, tm);
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            exp_t a;
            int   id;
            e = exp_q.pop_front();
            id = id_q.pop_front();
            a.st = game_state; a.me = move_en; a.rs = respawn; a.cl = clear_score;
            a.lv = lives; a.lev = level; a.tm = timer;
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL step%0d: got st=%0d me=%0b rs=%0b cl=%0b lives=%0d level=%0d timer=%0d, expected st=%0d me=%0b rs=%0b cl=%0b lives=%0d level=%0d timer=%0d",
                         id, a.st, a.me, a.rs, a.cl, a.lv, a.lev, a.tm,
                         e.st, e.me, e.rs, e.cl, e.lv, e.lev, e.tm);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state, then release
        cyc(0,0,0,0, ID,0,0,0,2,1,3);
        rst_n = 1'b1;
        cyc(0,1,1,0, ID,0,0,0,2,1,3);
        // Start edge, held button, release
        cyc(1,0,0,0, PL,1,1,1,2,1,3);
        cyc(1,0,0,0, PL,1,0,0,2,1,3);
        cyc(0,0,0,0, PL,1,0,0,2,1,3);
        // Timer run-down: 6 ticks, one idle cycle in between
        cyc(0,1,0,0, PL,1,0,0,2,1,3);
        cyc(0,0,0,0, PL,1,0,0,2,1,3);
        cyc(0,1,0,0, PL,1,0,0,2,1,2);
        cyc(0,1,0,0, PL,1,0,0,2,1,2);
        cyc(0,1,0,0, PL,1,0,0,2,1,1);
        cyc(0,1,0,0, PL,1,0,0,2,1,1);
        cyc(0,1,0,0, DY,0,0,0,1,1,0);
        for (int i = 0; i < 3; i++) cyc(0,1,0,0, DY,0,0,0,1,1,0);
        cyc(0,1,0,0, PL,1,1,0,1,1,3);
        // Two pads -> level up
        cyc(0,0,0,1, PL,1,0,0,1,1,3);
        cyc(0,0,0,2, LU,0,0,0,1,1,3);
        for (int i = 0; i < 2; i++) cyc(0,1,0,2, LU,0,0,0,1,1,3);
        cyc(0,1,0,2, PL,1,1,0,1,2,3);
        // Score decrease ignored, then fatal collision with one life left
        cyc(0,0,0,0, PL,1,0,0,1,2,3);
        cyc(0,0,1,0, DY,0,0,0,0,2,3);
        cyc(0,1,1,0, DY,0,0,0,0,2,3);
        for (int i = 0; i < 2; i++) cyc(0,1,0,0, DY,0,0,0,0,2,3);
        cyc(0,1,0,0, GO,0,0,0,0,2,3);
        cyc(0,1,1,0, GO,0,0,0,0,2,3);
        // Restart, two collisions to game over
        cyc(1,0,0,0, PL,1,1,1,2,1,3);
        cyc(0,0,0,0, PL,1,0,0,2,1,3);
        cyc(0,0,1,0, DY,0,0,0,1,1,3);
        for (int i = 0; i < 3; i++) cyc(0,1,0,0, DY,0,0,0,1,1,3);
        cyc(0,1,0,0, PL,1,1,0,1,1,3);
        cyc(0,0,1,0, DY,0,0,0,0,1,3);
        for (int i = 0; i < 3; i++) cyc(0,1,0,0, DY,0,0,0,0,1,3);
        cyc(0,1,0,0, GO,0,0,0,0,1,3);
        cyc(1,0,0,0, PL,1,1,1,2,1,3);
        cyc(0,0,0,0, PL,1,0,0,2,1,3);
        // Collision together with a pad: pad is not counted
        cyc(0,0,1,1, DY,0,0,0,1,1,3);
        for (int i = 0; i < 3; i++) cyc(0,1,0,1, DY,0,0,0,1,1,3);
        cyc(0,1,0,1, PL,1,1,0,1,1,3);
        cyc(0,0,0,2, PL,1,0,0,1,1,3);
        // Asynchronous reset in the middle of DYING
        cyc(0,0,1,2, DY,0,0,0,0,1,3);
        cyc(0,1,0,2, DY,0,0,0,0,1,3);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        push(ID,0,0,0,2,1,3);
        cyc(0,0,0,0, ID,0,0,0,2,1,3);
        rst_n = 1'b1;
        cyc(1,0,0,0, PL,1,1,1,2,1,3);
        repeat (2) @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frogger_game_seq.md
Name: frogger_game_seq

Overview:
- Game-level sequencer for the Frogger datapath; sits above the frog movement controller and the lane/obstacle logic.
- Owns the run state (title, play, death animation, level-up, game over), lives, level and the per-round countdown timer.
- Gates frog movement, requests respawn and score clear, and publishes level for lane speed selection.
- Advances only on frame ticks from the VGA timing block.

Parameters:
- LIVES_INIT, 3, lives at game start (1..7).
- TICKS_PER_SEC, 60, frame ticks per timer second (1..127).
- ROUND_SECS, 30, round timer reload value in seconds (1..63).
- DEATH_FRAMES, 90, frame ticks spent in DYING (1..127).
- LEVELUP_FRAMES, 60, frame ticks spent in LEVEL_UP (1..127).
- PADS_PER_LEVEL, 5, lily pads to fill before a level-up (1..7).
- MAX_LEVEL, 7, level saturation value (1..7).

Ports:
- i_Clk, in, 1, system clock.
- i_Rst_L, in, 1, asynchronous active-low reset.
- i_Frame_Tick, in, 1, one-cycle pulse per video frame.
- i_Start, in, 1, start button, level signal, already debounced.
- i_Collided, in, 1, frog hit or drowned, level signal.
- i_Score, in, 7, score from the frog controller.
- o_Game_State, out, 3, encoding: IDLE=0, PLAY=1, DYING=2, LEVEL_UP=3, GAME_OVER=4.
- o_Move_En, out, 1, frog movement allowed.
- o_Respawn, out, 1, one-cycle pulse: place frog at the start cell.
- o_Clear_Score, out, 1, one-cycle pulse: zero the score.
- o_Lives, out, 3, remaining lives.
- o_Level, out, 3, current level (1..MAX_LEVEL); drives lane speed select.
- o_Timer, out, 6, seconds remaining in the round.

Behaviour:
- Reset (async, i_Rst_L=0):
  - State IDLE, o_Lives=LIVES_INIT, o_Level=1, o_Timer=ROUND_SECS.
  - Pad count 0, frame counters 0.
  - o_Move_En, o_Respawn and o_Clear_Score all 0.
  - Start and score history registers cleared.
  - Reset mid-animation aborts immediately to this state.
- All outputs are registered; state changes are visible one cycle after the qualifying input edge.
- Start edge: i_Start=1 with the previous-cycle sample 0. A held button does not retrigger.
- Pad event: in PLAY, i_Score > previous-cycle i_Score (unsigned). Decreases, including a clear, are ignored.
- IDLE / GAME_OVER:
  - o_Move_En=0; inputs other than start edge ignored.
  - On start edge: go to PLAY; lives=LIVES_INIT, level=1, timer=ROUND_SECS, pad count=0, sec counter=0.
  - Same cycle: pulse o_Respawn and o_Clear_Score for 1 cycle.
- PLAY:
  - o_Move_En=1. Each i_Frame_Tick increments the sec counter.
  - When the sec counter reaches TICKS_PER_SEC-1 on a tick: counter=0 and timer decrements.
  - Events are evaluated in the same cycle, in priority order:
    - (1) i_Collided=1: go to DYING.
    - (2) Pad event: increment pad count. If the new count equals PADS_PER_LEVEL, go to LEVEL_UP; otherwise stay.
    - (3) Timer decrement from 1 to 0: go to DYING.
  - A collision in the same cycle as a pad event counts as a death only; the pad is not counted.
- DYING:
  - Entered with o_Move_En=0 and lives decremented by 1 (saturates at 0).
  - Frame counter cleared on entry; counts i_Frame_Tick.
  - On the DEATH_FRAMES-th tick: if lives=0, go to GAME_OVER. Otherwise go to PLAY with timer=ROUND_SECS, sec counter=0 and a 1-cycle o_Respawn.
  - Pad count is kept across the death.
  - i_Collided is ignored in this state.
- LEVEL_UP:
  - o_Move_En=0; frame counter cleared on entry.
  - On the LEVELUP_FRAMES-th tick: level=min(level+1, MAX_LEVEL), pad count=0, timer=ROUND_SECS, go to PLAY, 1-cycle o_Respawn.
  - The score is not cleared.
- GAME_OVER: o_Lives=0, o_Level and o_Timer hold their last values until the next start edge.
- Unused state encodings (5..7) return to IDLE on the next clock.
- Timer never wraps: no decrement occurs when the timer is 0.

Test Plan:
Bench parameters: TICKS_PER_SEC=2, ROUND_SECS=3, DEATH_FRAMES=4, LEVELUP_FRAMES=3, LIVES_INIT=2, PADS_PER_LEVEL=2.
- Reset, then pulse i_Start -> o_Game_State=1, o_Respawn and o_Clear_Score high for exactly 1 cycle, o_Lives=2, o_Timer=3, o_Move_En=1. Holding i_Start high gives no further pulses.
- In PLAY, 6 frame ticks with no events -> o_Timer steps 3,2,1,0. On the tick where it reaches 0, state goes to DYING and o_Lives=1. After 4 ticks: PLAY, o_Respawn pulse, o_Timer=3.
- i_Score 0->1 then 1->2 in PLAY -> LEVEL_UP after the second step. After 3 ticks: o_Level=2, PLAY, o_Respawn pulse, o_Clear_Score stays 0.
- i_Collided twice with lives=2, each death animation completed -> second DYING ends in GAME_OVER, o_Lives=0, o_Move_En=0. Start edge -> PLAY, o_Lives=2, o_Level=1.
- Same cycle: i_Collided=1 and i_Score 0->1 -> DYING; the pad count stays 0, confirmed because the next single pad does not trigger LEVEL_UP.
- Assert i_Rst_L low mid-DYING -> outputs return to reset values immediately, without waiting for a clock edge.
